// File: rtl/cordic_multi.sv
// Iterative CORDIC engine: vectoring (magnitude/phase) and rotation modes with
// full-circle quadrant correction, gain compensation and output saturation.
module cordic_multi #(
  parameter int WIDTH = 32,
  parameter int ITERS = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_angle,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] out_angle,
  output logic             overflow
);

  localparam int XW = WIDTH + 2;
  localparam int PW = XW + WIDTH + 1;
  localparam int CW = $clog2(ITERS);
  localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH:0] K_S = (WIDTH+1)'(longint'(0.6072529350 * (2.0 ** WIDTH)));
  localparam logic signed [PW-1:0] MAXV = PW'({4'b0000, {(WIDTH-1){1'b1}}});
  localparam logic signed [PW-1:0] MINV = -MAXV;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ITER, S_POST, S_DONE} state_t;

  // Binary-angle arctangent of 2^-i, rounded to nearest.
  function automatic logic [WIDTH-1:0] atan_entry(input int i);
    real v;
    v = $atan(2.0 ** (-i)) * (2.0 ** WIDTH) / (2.0 * 3.14159265358979323846);
    return WIDTH'(longint'(v));
  endfunction

  logic [WIDTH-1:0] atan_tab [ITERS];
  for (genvar g = 0; g < ITERS; g++) begin : g_atan
    assign atan_tab[g] = atan_entry(g);
  end

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic                    mode_r;
  logic                    zero_r;
  logic signed [XW-1:0]    x_r;
  logic signed [XW-1:0]    y_r;
  logic [WIDTH-1:0]        z_r;

  logic                    pre_flip;
  logic [WIDTH-1:0]        pre_z;
  logic                    d_pos;
  logic signed [XW-1:0]    x_sh;
  logic signed [XW-1:0]    y_sh;
  logic signed [XW-1:0]    x_nx;
  logic signed [XW-1:0]    y_nx;
  logic [WIDTH-1:0]        z_nx;
  logic signed [PW-1:0]    prod_x;
  logic signed [PW-1:0]    prod_y;
  logic signed [PW-1:0]    scl_x;
  logic signed [PW-1:0]    scl_y;
  logic                    clip_x;
  logic                    clip_y;
  logic [WIDTH-1:0]        sat_x;
  logic [WIDTH-1:0]        sat_y;

  always_comb begin
    // Fold the left half-plane onto the right so the micro-rotations converge.
    pre_flip = mode_r ? (z_r[WIDTH-1] ^ z_r[WIDTH-2]) : x_r[XW-1];
    if (mode_r) pre_z = pre_flip ? (z_r - HALF) : z_r;
    else        pre_z = pre_flip ? HALF : '0;

    d_pos = mode_r ? ~z_r[WIDTH-1] : y_r[XW-1];
    x_sh  = x_r >>> cnt;
    y_sh  = y_r >>> cnt;
    x_nx  = d_pos ? (x_r - y_sh) : (x_r + y_sh);
    y_nx  = d_pos ? (y_r + x_sh) : (y_r - x_sh);
    z_nx  = d_pos ? (z_r - atan_tab[cnt]) : (z_r + atan_tab[cnt]);

    prod_x = PW'(x_r) * PW'(K_S);
    prod_y = PW'(y_r) * PW'(K_S);
    scl_x  = prod_x >>> WIDTH;
    scl_y  = prod_y >>> WIDTH;
    clip_x = (scl_x > MAXV) || (scl_x < MINV);
    clip_y = (scl_y > MAXV) || (scl_y < MINV);
    if (scl_x > MAXV)      sat_x = MAXV[WIDTH-1:0];
    else if (scl_x < MINV) sat_x = MINV[WIDTH-1:0];
    else                   sat_x = scl_x[WIDTH-1:0];
    if (scl_y > MAXV)      sat_y = MAXV[WIDTH-1:0];
    else if (scl_y < MINV) sat_y = MINV[WIDTH-1:0];
    else                   sat_y = scl_y[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_angle <= '0;
      overflow  <= 1'b0;
      cnt       <= '0;
      mode_r    <= 1'b0;
      zero_r    <= 1'b0;
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            x_r    <= XW'($signed(in_x));
            y_r    <= XW'($signed(in_y));
            z_r    <= in_angle;
            mode_r <= mode;
            zero_r <= (in_x == '0) && (in_y == '0);
            ready  <= 1'b0;
            state  <= S_PRE;
          end
        end
        S_PRE: begin
          if (pre_flip) begin
            x_r <= -x_r;
            y_r <= -y_r;
          end
          z_r   <= pre_z;
          cnt   <= '0;
          state <= S_ITER;
        end
        S_ITER: begin
          x_r <= x_nx;
          y_r <= y_nx;
          z_r <= z_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITERS - 1)) state <= S_POST;
        end
        S_POST: begin
          out_x     <= sat_x;
          out_y     <= sat_y;
          // A zero vector has no defined phase; report 0 rather than the drifted z.
          out_angle <= (zero_r && !mode_r) ? '0 : z_r;
          overflow  <= clip_x | clip_y;
          done      <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
